// File: rtl/ofifo_col_if.sv
// Column output-FIFO bus: per-lane write strobes/data in, gang pop and head/status out.
// Master drives writes and pops; slave is the FIFO. o_ovf exists only with OFIFO_COL_OVF_FLAG_EN.
interface ofifo_col_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [col-1:0]         wr;
    logic [col*psum_bw-1:0] in;
    logic                   rd;
    logic [col*psum_bw-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
`ifdef OFIFO_COL_OVF_FLAG_EN
    logic                   o_ovf;
`endif

    modport master (
        output wr, in, rd,
        input  out, o_valid, o_full, o_ready
`ifdef OFIFO_COL_OVF_FLAG_EN
        , input o_ovf
`endif
    );

    modport slave (
        input  wr, in, rd,
        output out, o_valid, o_full, o_ready
`ifdef OFIFO_COL_OVF_FLAG_EN
        , output o_ovf
`endif
    );
endinterface

// File: rtl/ofifo_col.sv
// Per-column output FIFO lanes with a gang pop; heads fall through combinationally (0-cycle read, write visible next cycle).
// Lanes fill independently; o_full/o_ready throttle the array; writes to a full lane drop unless popped that cycle
// (OFIFO_COL_OVF_FLAG_EN adds a sticky o_ovf drop flag).
module ofifo_col #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    ofifo_col_if.slave bus
);
    localparam int pw = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [pw:0] cnt_full = (pw+1)'(depth);

    logic [psum_bw-1:0]     mem [col][depth];
    logic [pw-1:0]          wr_ptr [col];
    logic [pw-1:0]          rd_ptr [col];
    logic [pw:0]            cnt    [col];
    logic [col-1:0]         lane_full;
    logic [col-1:0]         lane_nempty;
    logic [col-1:0]         wr_acc;
    logic [col*psum_bw-1:0] out_dat;
    logic                   valid;
    logic                   pop;

    always_comb begin
        lane_full   = '0;
        lane_nempty = '0;
        out_dat     = '0;
        for (int i = 0; i < col; i++) begin
            lane_full[i]   = (cnt[i] == cnt_full);
            lane_nempty[i] = (cnt[i] != '0);
            out_dat[i*psum_bw +: psum_bw] = mem[i][rd_ptr[i]];
        end
    end

    assign valid  = &lane_nempty;
    assign pop    = bus.rd & valid;
    // A full lane still takes a write when the gang pop frees a slot in the same cycle.
    assign wr_acc = bus.wr & (~lane_full | {col{pop}});

    assign bus.o_valid = valid;
    assign bus.o_full  = |lane_full;
    assign bus.o_ready = ~(|lane_full);
    assign bus.out     = out_dat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < col; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_acc[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop)       rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({wr_acc[i], pop})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (reset_n && wr_acc[i]) mem[i][wr_ptr[i]] <= bus.in[i*psum_bw +: psum_bw];
        end
    end

`ifdef OFIFO_COL_OVF_FLAG_EN
    logic [col-1:0] wr_drop;
    logic           ovf;

    assign wr_drop = bus.wr & ~wr_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      ovf <= 1'b0;
        else if (|wr_drop) ovf <= 1'b1;
    end

    assign bus.o_ovf = ovf;
`endif
endmodule

// File: tb/tb_ofifo_col.sv
// Randomized and directed stimulus for ofifo_col checked against a queue-per-lane reference model.
module tb_ofifo_col;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 8;
    localparam int W   = COL*BW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [BW-1:0] mq [COL][$];
    logic          m_ovf = 1'b0;

    ofifo_col_if #(.col(COL), .psum_bw(BW)) bus();
    ofifo_col #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        bit v = 1'b1;
        for (int i = 0; i < COL; i++) if (mq[i].size() == 0) v = 1'b0;
        return v;
    endfunction

    function automatic bit m_full();
        bit f = 1'b0;
        for (int i = 0; i < COL; i++) if (mq[i].size() == DEP) f = 1'b1;
        return f;
    endfunction

    task automatic check_outputs();
        logic [W-1:0] e = '0;
        bit v = m_valid();
        bit f = m_full();
        chk("o_valid", W'(bus.o_valid), W'(v));
        chk("o_full",  W'(bus.o_full),  W'(f));
        chk("o_ready", W'(bus.o_ready), W'(!f));
        if (v) begin
            for (int i = 0; i < COL; i++) e[i*BW +: BW] = mq[i][0];
            chk("out", bus.out, e);
        end
`ifdef OFIFO_COL_OVF_FLAG_EN
        chk("o_ovf", W'(bus.o_ovf), W'(m_ovf));
`endif
    endtask

    // One clock: check current outputs, apply inputs, advance the model, step past the edge.
    task automatic cycle(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
        bit pop;
        bit acc [COL];
        check_outputs();
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        pop = r && m_valid();
        for (int i = 0; i < COL; i++) begin
            acc[i] = w[i] && (mq[i].size() < DEP || pop);
            if (w[i] && !acc[i]) m_ovf = 1'b1;
        end
        for (int i = 0; i < COL; i++) begin
            if (pop) void'(mq[i].pop_front());
            if (acc[i]) mq[i].push_back(d[i*BW +: BW]);
        end
        @(posedge clk);
        #1;
        bus.wr = '0;
        bus.rd = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_valid", W'(bus.o_valid), '0);
        chk("rst_full",  W'(bus.o_full),  '0);
        chk("rst_ready", W'(bus.o_ready), W'(1));
`ifdef OFIFO_COL_OVF_FLAG_EN
        chk("rst_ovf",   W'(bus.o_ovf),   '0);
`endif
        for (int i = 0; i < COL; i++) mq[i].delete();
        m_ovf = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_dat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] e;
        logic [BW-1:0] v16;
        bus.wr = '0;
        bus.in = '0;
        bus.rd = 1'b0;
        #12;
        chk("rst_valid", W'(bus.o_valid), '0);
        chk("rst_full",  W'(bus.o_full),  '0);
        chk("rst_ready", W'(bus.o_ready), W'(1));
        reset_n = 1'b1;

        // Skewed arrivals, lane i carries i+1.
        e = '0;
        for (int i = 0; i < COL; i++) begin
            d = '0;
            d[i*BW +: BW] = BW'(i + 1);
            e[i*BW +: BW] = BW'(i + 1);
            if (i == COL-1) chk("skew_not_yet", W'(bus.o_valid), '0);
            cycle(COL'(1) << i, d, 1'b0);
        end
        chk("skew_valid", W'(bus.o_valid), W'(1));
        chk("skew_out", bus.out, e);
        cycle('0, '0, 1'b1);
        chk("skew_drained", W'(bus.o_valid), '0);

        // Fill and drain.
        for (int k = 0; k < DEP; k++) begin
            v16 = BW'(k);
            cycle('1, {COL{v16}}, 1'b0);
        end
        chk("fill_full",  W'(bus.o_full),  W'(1));
        chk("fill_ready", W'(bus.o_ready), '0);
        for (int k = 0; k < DEP; k++) begin
            v16 = BW'(k);
            chk("drain_seq", bus.out, {COL{v16}});
            cycle('0, '0, 1'b1);
        end
        chk("drain_empty", W'(bus.o_valid), '0);

        // Full lanes: write+pop keeps count, then a dropped write.
        for (int k = 0; k < DEP; k++) begin
            v16 = BW'(k + 16);
            cycle('1, {COL{v16}}, 1'b0);
        end
        v16 = 16'hAAAA;
        cycle('1, {COL{v16}}, 1'b1);
        chk("wrpop_full", W'(bus.o_full), W'(1));
        v16 = 16'h5555;
        cycle('1, {COL{v16}}, 1'b0);
`ifdef OFIFO_COL_OVF_FLAG_EN
        chk("drop_ovf", W'(bus.o_ovf), W'(1));
`endif
        for (int k = 0; k < DEP; k++) begin
            chk("no_5555", W'(bus.out[BW-1:0] == 16'h5555), '0);
            if (k == DEP-1) chk("aaaa_8th", W'(bus.out[BW-1:0]), W'(16'hAAAA));
            cycle('0, '0, 1'b1);
        end
        chk("drop_empty", W'(bus.o_valid), '0);

        // Pop request while lane 3 is empty must be ignored.
        cycle(8'hF7, rnd_dat(), 1'b0);
        cycle('0, '0, 1'b1);
        cycle(8'h08, rnd_dat(), 1'b0);
        chk("emptyrd_valid", W'(bus.o_valid), W'(1));
        cycle('0, '0, 1'b1);

        // Reset in the middle of a stream.
        for (int k = 0; k < 5; k++) cycle('1, rnd_dat(), 1'b0);
        pulse_reset();
        for (int k = 0; k < DEP; k++) cycle('1, rnd_dat(), 1'b0);
        chk("refill_full", W'(bus.o_full), W'(1));
        for (int k = 0; k < DEP; k++) cycle('0, '0, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [COL-1:0] w;
            logic r;
            w = COL'($urandom);
            if ((n / 300) % 2 == 1) w = w | COL'($urandom);
            r = ($urandom_range(0, 3) != 0);
            if (n % 700 == 699) pulse_reset();
            cycle(w, rnd_dat(), r);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
